usb_kbd_event_decoder: RTL and testbench
========================================

USB_KBD_EVENT_DECODER -- requirements
Module: usb_kbd_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter REPORT_BYTES, default 8, HID boot-keyboard report length; fixed at 8.
REQ-003 SHALL have port clk, input, 1, sole clock; report inputs are synchronous to it.
REQ-004 SHALL have port reset_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port report_i, input, 64, HID report: byte n = bits [8n+7:8n]; byte0 modifiers, byte1 reserved, bytes2-7 keycodes.
REQ-006 SHALL have port report_valid_i, input, 1, one-cycle strobe qualifying report_i.
REQ-007 SHALL have port event_o, output, 9, event: bit8 1 = press, 0 = release; bits7:0 HID usage.
REQ-008 SHALL have port event_valid_o, output, 1, FIFO non-empty.
REQ-009 SHALL have port event_ready_i, input, 1, consumer pop; the pop occurs when valid && ready.
REQ-010 SHALL have port mods_o, output, 8, last committed modifier byte.
REQ-011 SHALL have port overflow_o, output, 1, sticky event-dropped flag.
REQ-012 SHALL have port clear_overflow_i, input, 1, clears overflow_o.

Function
REQ-013 SHALL hold one pending report; report_valid_i overwrites the pending report, including while the FSM is busy (latest-wins).
REQ-014 SHALL use FSM states IDLE, MOD, REL, PRS, COMMIT; IDLE leaves to MOD on the cycle after pending becomes set and consumes pending (cur <= pending).
REQ-015 SHALL, in MOD, step index 0..7 one bit per cycle; a differing cur/prev modifier bit i pushes event {cur bit, 8'hE0+i}.
REQ-016 SHALL, in REL, step index 0..5; a nonzero prev key absent from all six cur keys pushes {0, key}.
REQ-017 SHALL, in PRS, step index 0..5; a nonzero cur key absent from all six prev keys pushes {1, key}.
REQ-018 SHALL, in COMMIT, set prev <= cur and mods_o <= cur byte0, then return to IDLE.
REQ-019 SHALL take a fixed 22 cycles from IDLE exit to IDLE (1+8+6+6+1).
REQ-020 SHALL, when any cur key byte equals 8'h01 (ErrorRollOver), go from IDLE directly back to IDLE: no events, prev unchanged.
REQ-021 SHALL ignore duplicate keycodes within one report after their first occurrence.
REQ-022 SHALL use a first-word-fall-through FIFO; a push into an empty FIFO is visible on event_o/event_valid_o the next cycle.
REQ-023 SHALL, on a push while full, drop the event and set overflow_o; a simultaneous pop while full accepts the push with no overflow.
REQ-024 SHALL give set priority when clear_overflow_i and an overflow occur in the same cycle.

Reset
REQ-025 SHALL, on reset_ni low, immediately force: FSM IDLE; prev, cur and pending zero; FIFO empty; event_o 0; event_valid_o 0; mods_o 0; overflow_o 0.
REQ-026 SHALL, on a reset mid-report, abort with no commit and drop any events already pushed.

Configuration
REQ-027 SHALL, with KBD_MODIFIER_EVENTS_EN defined, behave as REQ-015 and REQ-019.
REQ-028 SHALL, without KBD_MODIFIER_EVENTS_EN, skip MOD (IDLE goes to REL), emit no modifier events, still update mods_o, and take 14 cycles.

Structure
REQ-029 SHALL place in package usb_kbd_pkg: the state enum, event width 9, ERR_ROLLOVER = 8'h01 and MOD_USAGE_BASE = 8'hE0.
REQ-030 SHALL implement the event FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated once.

Verification
REQ-031 SHALL cover: single report, key 8'h04 in byte2, ready=1 -> one event 9'h104; then an all-zero report -> 9'h004.
REQ-032 SHALL cover: report with byte0 = 8'h02 -> 9'h1E1 (macro defined); the same stimulus without the macro -> no event, mods_o = 8'h02.
REQ-033 SHALL cover: prev keys {04,05}, new keys {05,06} -> events exactly 9'h004 then 9'h106.
REQ-034 SHALL cover: report with all six keys 8'h01 -> no events, prev unchanged, the following report diffs against the old prev.
REQ-035 SHALL cover: ready=0, FIFO_DEPTH=4, six new keys -> four events kept (first four), overflow_o=1; clear_overflow_i -> 0.
REQ-036 SHALL cover: reset_ni low mid-PRS -> all outputs 0 immediately; a subsequent report 8'h04 in byte2 -> 9'h104.

Source files
------------

// File: rtl/usb_kbd_pkg.sv
// Shared types and constants for the USB boot-keyboard event decoder.
package usb_kbd_pkg;

    localparam int         EVENT_W        = 9;
    localparam int         NUM_KEYS       = 6;
    localparam logic [7:0] ERR_ROLLOVER   = 8'h01;
    localparam logic [7:0] MOD_USAGE_BASE = 8'hE0;

    typedef enum logic [2:0] {
        IDLE,
        MOD,
        REL,
        PRS,
        COMMIT
    } state_e;

    function automatic logic has_rollover(input logic [8*NUM_KEYS-1:0] keys);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (keys[8*k +: 8] == ERR_ROLLOVER) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; data_o shows the head entry (zero when empty).
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot a full-FIFO push lands in.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/usb_kbd_event_decoder.sv
// Diffs successive HID boot-keyboard reports into press/release events.
// Define KBD_MODIFIER_EVENTS_EN to also emit events for modifier-bit changes.
module usb_kbd_event_decoder
    import usb_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int REPORT_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic [REPORT_BYTES*8-1:0] report_i,
    input  logic                      report_valid_i,
    output logic [EVENT_W-1:0]        event_o,
    output logic                      event_valid_o,
    input  logic                      event_ready_i,
    output logic [7:0]                mods_o,
    output logic                      overflow_o,
    input  logic                      clear_overflow_i
);
    localparam int KW = 8 * NUM_KEYS;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      pend_mods_q, pend_mods_d;
    logic [KW-1:0]   pend_keys_q, pend_keys_d;
    logic            pend_vld_q, pend_vld_d;
    logic [7:0]      cur_mods_q, cur_mods_d;
    logic [KW-1:0]   cur_keys_q, cur_keys_d;
    logic [KW-1:0]   prev_keys_q, prev_keys_d;
    logic [7:0]      mods_q, mods_d;
    logic            ovf_q, ovf_d;

    logic               push;
    logic [EVENT_W-1:0] push_data;
    logic               fifo_empty, fifo_full, pop;
    logic               unused_reserved;

    logic [7:0] key_a [NUM_KEYS];
    logic [7:0] key_b [NUM_KEYS];
    logic [7:0] probe;
    logic       hit, dup;

    assign unused_reserved = ^report_i[15:8];

    // REL scans prev against cur; PRS scans cur against prev.
    always_comb begin
        for (int j = 0; j < NUM_KEYS; j++) begin
            key_a[j] = (state_q == PRS) ? cur_keys_q[8*j +: 8]  : prev_keys_q[8*j +: 8];
            key_b[j] = (state_q == PRS) ? prev_keys_q[8*j +: 8] : cur_keys_q[8*j +: 8];
        end
        probe = '0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (idx_q == 3'(j)) probe = key_a[j];
        end
        hit = 1'b0;
        dup = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            if (key_b[j] == probe) hit = 1'b1;
            if ((3'(j) < idx_q) && (key_a[j] == probe)) dup = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pend_mods_d = pend_mods_q;
        pend_keys_d = pend_keys_q;
        pend_vld_d  = pend_vld_q;
        cur_mods_d  = cur_mods_q;
        cur_keys_d  = cur_keys_q;
        prev_keys_d = prev_keys_q;
        mods_d      = mods_q;
        push        = 1'b0;
        push_data   = '0;

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    pend_vld_d = 1'b0;
                    if (!has_rollover(pend_keys_q)) begin
                        cur_mods_d = pend_mods_q;
                        cur_keys_d = pend_keys_q;
                        idx_d      = '0;
`ifdef KBD_MODIFIER_EVENTS_EN
                        state_d    = MOD;
`else
                        state_d    = REL;
`endif
                    end
                end
            end
`ifdef KBD_MODIFIER_EVENTS_EN
            MOD: begin
                if (cur_mods_q[idx_q] != mods_q[idx_q]) begin
                    push      = 1'b1;
                    push_data = {cur_mods_q[idx_q], MOD_USAGE_BASE + {5'd0, idx_q}};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
                    idx_d   = '0;
                    state_d = REL;
                end
            end
`endif
            REL, PRS: begin
                if ((probe != 8'h00) && !hit && !dup) begin
                    push      = 1'b1;
                    push_data = {(state_q == PRS), probe};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'(NUM_KEYS - 1)) begin
                    idx_d   = '0;
                    state_d = (state_q == REL) ? PRS : COMMIT;
                end
            end
            COMMIT: begin
                prev_keys_d = cur_keys_q;
                mods_d      = cur_mods_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Latest report wins, even over the one being consumed this cycle.
        if (report_valid_i) begin
            pend_mods_d = report_i[7:0];
            pend_keys_d = report_i[16 +: KW];
            pend_vld_d  = 1'b1;
        end
    end

    assign pop   = event_valid_o && event_ready_i;
    assign ovf_d = (push && fifo_full && !pop) ? 1'b1 :
                   (clear_overflow_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_mods_q <= '0;
            pend_keys_q <= '0;
            pend_vld_q  <= 1'b0;
            cur_mods_q  <= '0;
            cur_keys_q  <= '0;
            prev_keys_q <= '0;
            mods_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_mods_q <= pend_mods_d;
            pend_keys_q <= pend_keys_d;
            pend_vld_q  <= pend_vld_d;
            cur_mods_q  <= cur_mods_d;
            cur_keys_q  <= cur_keys_d;
            prev_keys_q <= prev_keys_d;
            mods_q      <= mods_d;
            ovf_q       <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_ni (reset_ni),
        .push_i   (push),
        .data_i   (push_data),
        .pop_i    (pop),
        .data_o   (event_o),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign event_valid_o = !fifo_empty;
    assign mods_o        = mods_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_usb_kbd_event_decoder.sv
// Directed bench for usb_kbd_event_decoder with a report-diff reference model.
module tb_usb_kbd_event_decoder;
    logic        clk = 1'b0;
    logic        reset_ni;
    logic [63:0] report_i;
    logic        report_valid_i;
    logic [8:0]  event_o;
    logic        event_valid_o;
    logic        event_ready_i;
    logic [7:0]  mods_o;
    logic        overflow_o;
    logic        clear_overflow_i;

    always #5 clk = ~clk;

    usb_kbd_event_decoder #(.FIFO_DEPTH(4), .REPORT_BYTES(8)) dut (
        .clk              (clk),
        .reset_ni         (reset_ni),
        .report_i         (report_i),
        .report_valid_i   (report_valid_i),
        .event_o          (event_o),
        .event_valid_o    (event_valid_o),
        .event_ready_i    (event_ready_i),
        .mods_o           (mods_o),
        .overflow_o       (overflow_o),
        .clear_overflow_i (clear_overflow_i)
    );

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    logic [47:0] m_prev = '0;
    logic [7:0] m_mods = '0;
    logic [8:0] last_ev = '0;
    int         n_ev = 0;
    int         n0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every consumed event is checked against the model, in order.
    always @(negedge clk) begin
        if (reset_ni === 1'b1 && event_valid_o && event_ready_i) begin
            n_ev++;
            last_ev = event_o;
            if (exp_q.size() == 0) check("unexpected_event", {55'd0, event_o}, 64'h1_0000_0000);
            else check("event", {55'd0, event_o}, {55'd0, exp_q.pop_front()});
        end
    end

    function automatic logic [63:0] rpt(input logic [7:0] m, input logic [7:0] k0, input logic [7:0] k1,
                                        input logic [7:0] k2, input logic [7:0] k3,
                                        input logic [7:0] k4, input logic [7:0] k5);
        return {k5, k4, k3, k2, k1, k0, 8'h00, m};
    endfunction

    // Reference: set difference between the old and new key lists.
    task automatic model_report(input logic [63:0] r);
        bit         in_cur[256];
        bit         in_prev[256];
        bit         done[256];
        logic [7:0] k;
        for (int i = 0; i < 6; i++) if (r[16+8*i +: 8] == 8'h01) return;
        for (int i = 0; i < 256; i++) begin in_cur[i] = 0; in_prev[i] = 0; end
        for (int i = 0; i < 6; i++) begin
            in_cur[r[16+8*i +: 8]] = 1;
            in_prev[m_prev[8*i +: 8]] = 1;
        end
`ifdef KBD_MODIFIER_EVENTS_EN
        for (int i = 0; i < 8; i++)
            if (r[i] != m_mods[i]) exp_q.push_back({r[i], 8'hE0 + 8'(i)});
`endif
        for (int i = 0; i < 256; i++) done[i] = 0;
        for (int i = 0; i < 6; i++) begin
            k = m_prev[8*i +: 8];
            if (k != 0 && !in_cur[k] && !done[k]) exp_q.push_back({1'b0, k});
            done[k] = 1;
        end
        for (int i = 0; i < 256; i++) done[i] = 0;
        for (int i = 0; i < 6; i++) begin
            k = r[16+8*i +: 8];
            if (k != 0 && !in_prev[k] && !done[k]) exp_q.push_back({1'b1, k});
            done[k] = 1;
        end
        m_prev = r[63:16];
        m_mods = r[7:0];
    endtask

    task automatic send(input logic [63:0] r);
        @(posedge clk); #1;
        report_i       = r;
        report_valid_i = 1'b1;
        model_report(r);
        @(posedge clk); #1;
        report_valid_i = 1'b0;
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("mods", {56'd0, mods_o}, {56'd0, m_mods});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {63'd0, event_valid_o}, 64'd0);
        check({tag, "_event"}, {55'd0, event_o}, 64'd0);
        check({tag, "_mods"}, {56'd0, mods_o}, 64'd0);
        check({tag, "_ovf"}, {63'd0, overflow_o}, 64'd0);
    endtask

    initial begin
        reset_ni = 1'b0;
        report_i = '0;
        report_valid_i = 1'b0;
        event_ready_i = 1'b1;
        clear_overflow_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_ni = 1'b1;

        // Single press then release
        n0 = n_ev;
        send(rpt(8'h00, 8'h04, 0, 0, 0, 0, 0));
        settle();
        check("press_count", 64'(n_ev - n0), 64'd1);
        check("press_04", {55'd0, last_ev}, 64'h104);
        send(64'd0);
        settle();
        check("release_04", {55'd0, last_ev}, 64'h004);

        // Modifier only
        n0 = n_ev;
        send(rpt(8'h02, 0, 0, 0, 0, 0, 0));
        settle();
`ifdef KBD_MODIFIER_EVENTS_EN
        check("mod_press", {55'd0, last_ev}, 64'h1E1);
`else
        check("mod_no_event", 64'(n_ev - n0), 64'd0);
`endif
        check("mods_02", {56'd0, mods_o}, 64'h02);

        // Overlapping key sets
        send(rpt(8'h00, 8'h04, 8'h05, 0, 0, 0, 0));
        settle();
        n0 = n_ev;
        send(rpt(8'h00, 8'h05, 8'h06, 0, 0, 0, 0));
        settle();
        check("overlap_count", 64'(n_ev - n0), 64'd2);
        check("overlap_last", {55'd0, last_ev}, 64'h106);

        // ErrorRollOver leaves prev intact
        n0 = n_ev;
        send(rpt(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
        settle();
        check("rollover_none", 64'(n_ev - n0), 64'd0);
        n0 = n_ev;
        send(rpt(8'h00, 8'h06, 0, 0, 0, 0, 0));
        settle();
        check("after_rollover_count", 64'(n_ev - n0), 64'd1);
        check("after_rollover_ev", {55'd0, last_ev}, 64'h005);

        // Duplicate keycode in one report
        n0 = n_ev;
        send(rpt(8'h00, 8'h07, 8'h07, 8'h06, 0, 0, 0));
        settle();
        check("dup_count", 64'(n_ev - n0), 64'd1);
        check("dup_ev", {55'd0, last_ev}, 64'h107);
        send(64'd0);
        settle();

        // Overflow with consumer stalled
        event_ready_i = 1'b0;
        send(rpt(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        repeat (30) @(posedge clk);
        #1;
        check("ovf_set", {63'd0, overflow_o}, 64'd1);
        check("ovf_valid", {63'd0, event_valid_o}, 64'd1);
        check("ovf_head", {55'd0, event_o}, 64'h104);
        clear_overflow_i = 1'b1;
        @(posedge clk); #1;
        clear_overflow_i = 1'b0;
        check("ovf_cleared", {63'd0, overflow_o}, 64'd0);
        n0 = n_ev;
        event_ready_i = 1'b1;
        settle();
        check("ovf_kept", 64'(n_ev - n0), 64'd4);
        check("ovf_last", {55'd0, last_ev}, 64'h107);

        // Reset in the middle of the press scan
        send(rpt(8'h00, 8'h0A, 8'h0B, 8'h0C, 0, 0, 0));
`ifdef KBD_MODIFIER_EVENTS_EN
        repeat (16) @(posedge clk);
`else
        repeat (8) @(posedge clk);
`endif
        #1;
        reset_ni = 1'b0;
        exp_q.delete();
        m_prev = '0;
        m_mods = '0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_ni = 1'b1;
        n0 = n_ev;
        send(rpt(8'h00, 8'h04, 0, 0, 0, 0, 0));
        settle();
        check("post_reset_count", 64'(n_ev - n0), 64'd1);
        check("post_reset_ev", {55'd0, last_ev}, 64'h104);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
